attn_ram_pingpong: RTL and testbench

- Producer-side buffer for the Attn @ V stage.
- Accepts the score-spike words streamed out of the Q@K^T systolic stage and holds them in two banks (ping-pong).
- Serves the Attn@V calculator through a read port: Empty flag, read address, data with 1-cycle latency, and a Done pulse that releases a bank.
- Sits between the Q@K^T output and the Attn@V multiply engine, so one tile can be written while the previous tile is read.

---
 rtl/attn_ram_pingpong_pkg.sv | 15 +
 rtl/attn_ram_pingpong_if.sv | 28 ++
 rtl/attn_ram_pingpong_sdp_ram.sv | 36 +++
 rtl/attn_ram_pingpong.sv | 108 ++++++++++
 tb/tb_attn_ram_pingpong.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/attn_ram_pingpong_pkg.sv
// Shared sizing for the Attn@V score buffer: spike-word width and bank geometry.
// DATA_W carries one score per time step, each wide enough for 2*SYSTOLIC_UNIT_NUM.
package attn_ram_pingpong_pkg;

    localparam int SYSTOLIC_UNIT_NUM = 16;
    localparam int TIME_STEPS        = 4;
    localparam int DATA_W            = $clog2(2 * SYSTOLIC_UNIT_NUM) * TIME_STEPS;
    localparam int ADDR_W            = 12;
    localparam int ATTN_BANK_DEPTH   = 4096;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   len_t;

endpackage

// File: rtl/attn_ram_pingpong_if.sv
// Bus between the Q@K^T producer / Attn@V reader and the ping-pong buffer.
// Write side: a word moves when i_wr_valid && o_wr_ready are both high at a rising clk;
// valid never waits on ready. Read side: address in, data out one clk later.
interface attn_ram_pingpong_if
    import attn_ram_pingpong_pkg::*;
();

    logic  i_wr_valid;
    word_t i_wr_data;
    logic  i_wr_last;
    logic  o_wr_ready;
    logic  o_AttnRam_Empty;
    addr_t i_AttnRam_rd_addr;
    word_t o_AttnRam_data;
    logic  i_AttnRam_Done;
    len_t  o_AttnRam_len;

    modport slave (
        input  i_wr_valid, i_wr_data, i_wr_last, i_AttnRam_rd_addr, i_AttnRam_Done,
        output o_wr_ready, o_AttnRam_Empty, o_AttnRam_data, o_AttnRam_len
    );

    modport master (
        output i_wr_valid, i_wr_data, i_wr_last, i_AttnRam_rd_addr, i_AttnRam_Done,
        input  o_wr_ready, o_AttnRam_Empty, o_AttnRam_data, o_AttnRam_len
    );

endinterface

// File: rtl/attn_ram_pingpong_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-clk latency).
module attn_ram_pingpong_sdp_ram #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/attn_ram_pingpong.sv
// Two-bank ping-pong buffer: one tile is filled from Q@K^T while the other is read by Attn@V.
// Banks are handed over strictly in write order via 1-bit write/read pointers.
module attn_ram_pingpong
    import attn_ram_pingpong_pkg::*;
(
    input logic                 s_clk,
    input logic                 s_rst,
    attn_ram_pingpong_if.slave  bus
);

    logic [1:0] r_full;
    logic       r_wr_sel;
    logic       r_rd_sel;
    logic       r_rd_sel_q;
    addr_t      r_wr_addr;
    len_t       r_len [2];

    logic       w_wr_ready;
    logic       w_empty;
    logic       w_wr_fire;
    logic       w_close;
    logic       w_done;
    logic [1:0] w_full_next;
    len_t       w_len_next;
    word_t      w_rd_data0;
    word_t      w_rd_data1;

    assign w_wr_ready = !r_full[r_wr_sel];
    assign w_empty    = !r_full[r_rd_sel];
    assign w_wr_fire  = bus.i_wr_valid && w_wr_ready;
    // A full bank closes on its own at the last address; there is no wrap inside a tile.
    assign w_close    = w_wr_fire && (bus.i_wr_last || (r_wr_addr == ADDR_W'(ATTN_BANK_DEPTH - 1)));
    assign w_done     = bus.i_AttnRam_Done && !w_empty;
    assign w_len_next = len_t'(r_wr_addr) + len_t'(1);

    // Release is applied before close so a same-bank collision leaves the bank full.
    always_comb begin
        w_full_next = r_full;
        if (w_done) begin
            w_full_next[r_rd_sel] = 1'b0;
        end
        if (w_close) begin
            w_full_next[r_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_full     <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_rd_sel_q <= 1'b0;
            r_wr_addr  <= '0;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
        end else begin
            r_full     <= w_full_next;
            r_rd_sel_q <= r_rd_sel;
            if (w_wr_fire) begin
                if (w_close) begin
                    r_wr_addr       <= '0;
                    r_wr_sel        <= ~r_wr_sel;
                    r_len[r_wr_sel] <= w_len_next;
                end else begin
                    r_wr_addr <= r_wr_addr + addr_t'(1);
                end
            end
            if (w_done) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

    attn_ram_pingpong_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (ATTN_BANK_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .i_clk     (s_clk),
        .i_rst     (s_rst),
        .i_wr_en   (w_wr_fire && !r_wr_sel),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (bus.i_wr_data),
        .i_rd_addr (bus.i_AttnRam_rd_addr),
        .o_rd_data (w_rd_data0)
    );

    attn_ram_pingpong_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (ATTN_BANK_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .i_clk     (s_clk),
        .i_rst     (s_rst),
        .i_wr_en   (w_wr_fire && r_wr_sel),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (bus.i_wr_data),
        .i_rd_addr (bus.i_AttnRam_rd_addr),
        .o_rd_data (w_rd_data1)
    );

    // r_rd_sel_q lines the bank mux up with the RAM's registered read.
    assign bus.o_AttnRam_data  = r_rd_sel_q ? w_rd_data1 : w_rd_data0;
    assign bus.o_wr_ready      = w_wr_ready;
    assign bus.o_AttnRam_Empty = w_empty;
    assign bus.o_AttnRam_len   = r_len[r_rd_sel];

endmodule

// File: tb/tb_attn_ram_pingpong.sv
// Directed bench for attn_ram_pingpong: tile transfer, backpressure, forced close,
// simultaneous close/Done, spurious Done and mid-tile reset.
module tb_attn_ram_pingpong;
    import attn_ram_pingpong_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [DATA_W-1:0] exp_q[$];

    attn_ram_pingpong_if bus();

    attn_ram_pingpong u_dut (
        .s_clk (clk),
        .s_rst (rst),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic write_word(input logic [DATA_W-1:0] d, input logic last, input logic done);
        check_eq("wr_ready_pre", 32'(bus.o_wr_ready), 32'd1);
        bus.i_wr_valid     = 1'b1;
        bus.i_wr_data      = d;
        bus.i_wr_last      = last;
        bus.i_AttnRam_Done = done;
        exp_q.push_back(d);
        step();
        bus.i_wr_valid     = 1'b0;
        bus.i_wr_last      = 1'b0;
        bus.i_AttnRam_Done = 1'b0;
    endtask

    task automatic read_tile(input int n, input string tag);
        logic [DATA_W-1:0] exp;
        for (int a = 0; a < n; a++) begin
            bus.i_AttnRam_rd_addr = ADDR_W'(a);
            step();
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scoreboard_empty got=%h exp=none", tag, bus.o_AttnRam_data);
            end else begin
                exp = exp_q.pop_front();
                check_eq(tag, 32'(bus.o_AttnRam_data), 32'(exp));
            end
        end
    endtask

    task automatic pulse_done();
        bus.i_AttnRam_Done = 1'b1;
        step();
        bus.i_AttnRam_Done = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_wr_valid        = 1'b0;
        bus.i_wr_data         = '0;
        bus.i_wr_last         = 1'b0;
        bus.i_AttnRam_rd_addr = '0;
        bus.i_AttnRam_Done    = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_empty", 32'(bus.o_AttnRam_Empty), 32'd1);
        check_eq("rst_ready", 32'(bus.o_wr_ready), 32'd1);
        check_eq("rst_len",   32'(bus.o_AttnRam_len), 32'd0);
        check_eq("rst_data",  32'(bus.o_AttnRam_data), 32'd0);

        // Basic 8-word tile into bank 0
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check_eq("basic_empty_pre", 32'(bus.o_AttnRam_Empty), 32'd1);
            write_word(DATA_W'(i + 1), (i == 7), 1'b0);
        end
        check_eq("basic_empty", 32'(bus.o_AttnRam_Empty), 32'd0);
        check_eq("basic_len",   32'(bus.o_AttnRam_len), 32'd8);
        read_tile(8, "basic_data");
        pulse_done();
        check_eq("basic_done_empty", 32'(bus.o_AttnRam_Empty), 32'd1);

        // Backpressure: tile A -> bank 1, tile B -> bank 0, no Done in between
        for (int i = 0; i < 4; i++) write_word(DATA_W'(32'hA0000 + i), (i == 3), 1'b0);
        for (int i = 0; i < 4; i++) write_word(DATA_W'(32'hB0000 + i), (i == 3), 1'b0);
        check_eq("bp_ready_low", 32'(bus.o_wr_ready), 32'd0);
        check_eq("bp_empty",     32'(bus.o_AttnRam_Empty), 32'd0);
        check_eq("bp_len_a",     32'(bus.o_AttnRam_len), 32'd4);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = DATA_W'(32'hDEAD0);
        bus.i_wr_last  = 1'b1;
        step();
        bus.i_wr_valid = 1'b0;
        bus.i_wr_last  = 1'b0;
        check_eq("bp_ready_hold", 32'(bus.o_wr_ready), 32'd0);
        read_tile(4, "bp_data_a");
        pulse_done();
        check_eq("bp_done_empty", 32'(bus.o_AttnRam_Empty), 32'd0);
        check_eq("bp_done_ready", 32'(bus.o_wr_ready), 32'd1);
        check_eq("bp_len_b",      32'(bus.o_AttnRam_len), 32'd4);
        read_tile(4, "bp_data_b");
        pulse_done();
        check_eq("bp_final_empty", 32'(bus.o_AttnRam_Empty), 32'd1);

        // Simultaneous: B closes on the same edge that A is released
        for (int i = 0; i < 3; i++) write_word(DATA_W'(32'h1A000 + i), (i == 2), 1'b0);
        check_eq("sim_len_a", 32'(bus.o_AttnRam_len), 32'd3);
        read_tile(3, "sim_data_a");
        for (int i = 0; i < 4; i++) write_word(DATA_W'(32'h1B000 + i), (i == 3), (i == 3));
        check_eq("sim_empty", 32'(bus.o_AttnRam_Empty), 32'd0);
        check_eq("sim_ready", 32'(bus.o_wr_ready), 32'd1);
        check_eq("sim_len_b", 32'(bus.o_AttnRam_len), 32'd4);
        read_tile(4, "sim_data_b");
        pulse_done();
        check_eq("sim_final_empty", 32'(bus.o_AttnRam_Empty), 32'd1);

        // Reset mid-tile, then a spurious Done, then a fresh tile in bank 0
        for (int i = 0; i < 3; i++) write_word(DATA_W'(32'h77000 + i), 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check_eq("mrst_empty", 32'(bus.o_AttnRam_Empty), 32'd1);
        check_eq("mrst_ready", 32'(bus.o_wr_ready), 32'd1);
        check_eq("mrst_len",   32'(bus.o_AttnRam_len), 32'd0);
        check_eq("mrst_data",  32'(bus.o_AttnRam_data), 32'd0);
        pulse_done();
        check_eq("spur_empty", 32'(bus.o_AttnRam_Empty), 32'd1);
        check_eq("spur_ready", 32'(bus.o_wr_ready), 32'd1);
        write_word(DATA_W'(32'hC0001), 1'b0, 1'b0);
        write_word(DATA_W'(32'hC0002), 1'b1, 1'b0);
        check_eq("mrst_tile_empty", 32'(bus.o_AttnRam_Empty), 32'd0);
        check_eq("mrst_tile_len",   32'(bus.o_AttnRam_len), 32'd2);
        read_tile(2, "mrst_tile_data");
        pulse_done();

        // Forced close at DEPTH words into bank 1, next word lands at bank 0 addr 0
        for (int i = 0; i < ATTN_BANK_DEPTH; i++) begin
            if (i == ATTN_BANK_DEPTH - 1)
                check_eq("force_empty_pre", 32'(bus.o_AttnRam_Empty), 32'd1);
            write_word(DATA_W'(i * 3 + 5), 1'b0, 1'b0);
        end
        check_eq("force_empty", 32'(bus.o_AttnRam_Empty), 32'd0);
        check_eq("force_len",   32'(bus.o_AttnRam_len), 32'd4096);
        check_eq("force_ready", 32'(bus.o_wr_ready), 32'd1);
        write_word(DATA_W'(32'h55555), 1'b1, 1'b0);
        check_eq("force_ready_after", 32'(bus.o_wr_ready), 32'd0);
        read_tile(ATTN_BANK_DEPTH, "force_data");
        pulse_done();
        check_eq("force_next_empty", 32'(bus.o_AttnRam_Empty), 32'd0);
        check_eq("force_next_len",   32'(bus.o_AttnRam_len), 32'd1);
        read_tile(1, "force_next_data");
        pulse_done();
        check_eq("force_final_empty", 32'(bus.o_AttnRam_Empty), 32'd1);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
